l1d_port_arbiter: RTL and testbench
===================================

// Module: l1d_port_arbiter
// PURPOSE
//   Shares the single L1 data cache port among NUM_REQ requesters (e.g. load unit,
//   store-buffer drain). Grants one requester at a time with round-robin priority.
//   Sequences the cache valid/status handshake and routes the response back to the
//   granted requester. Sits between the LSU-side clients and the L1 D-cache.
// PARAMETERS
//   NUM_REQ  2  number of requesters (2..8); all widths below derive from it
// PORTS
//   clk            in   1          clock, single domain
//   rst            in   1          synchronous reset, active-high
//   req_valid      in   NUM_REQ    per-requester request pending
//   req_addr       in   NUM_REQ*32 per-requester byte address, slice i = [32*i+:32]
//   req_we         in   NUM_REQ    1 = write, 0 = read
//   req_wdata      in   NUM_REQ*32 per-requester write data
//   req_ready      out  NUM_REQ    one-hot pulse: request i accepted this cycle
//   resp_valid     out  NUM_REQ    one-hot pulse: access of requester i complete
//   resp_rdata     out  32         read data, qualified by resp_valid
//   cache_valid    out  1          to cache valid
//   cache_addr     out  32         to cache addr
//   cache_we       out  1          to cache write_enabled
//   cache_wdata    out  32         to cache w_data
//   cache_rdata    in   32         from cache r_data
//   cache_status   in   2          from cache: 0 idle, 1 busy, 2 done (1 cycle)
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=0. All outputs 0: req_ready, resp_valid, resp_rdata,
//   cache_valid, cache_addr, cache_we, cache_wdata. Latched request registers cleared.
// - Reset mid-operation: abandon any transaction, drop any pending response, return
//   to IDLE next cycle. The cache shares rst, so no cleanup is required.
// - FSM states: IDLE, ISSUE, WAIT.
//   IDLE:
//     - Grant only if |req_valid and cache_status==0.
//     - Winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//     - Same cycle: req_ready[winner]=1 (combinational), latch addr/we/wdata/winner id.
//     - rr_ptr <= (winner+1) mod NUM_REQ; next state ISSUE.
//     - If cache_status!=0, stay in IDLE with no grant.
//   ISSUE:
//     - cache_valid=1 for exactly this one cycle; cache_* driven from latched registers.
//     - Next state WAIT, unconditionally.
//   WAIT:
//     - cache_valid=0. Hold until cache_status==2.
//     - On that cycle X: register resp_rdata (= cache_rdata for a read, 32'h0 for a write).
//     - resp_valid[id]=1 during X+1 only; state IDLE at X+1.
// - Latency: grant at A, ISSUE at A+1; cache done at A+L+2 for cache latency L.
//   resp_valid at A+L+3; the next grant can occur at A+L+3.
//   With L=1, a hit response arrives 4 cycles after grant.
// - Requesters hold req_* stable until req_ready. The latched copy is then used, so
//   req_* may change the cycle after acceptance. A requester may re-request while its
//   response is outstanding; it is not granted before the current transaction ends.
// - cache_valid is never high outside ISSUE. This prevents the cache from re-accepting
//   a request in the cycle it returns to status 0.
// - Fairness: a requester holding req_valid waits at most NUM_REQ-1 transactions.
// - Illegal cache_status==3 in WAIT: treated as busy (keep waiting).
// CONFIGURATION
//   L1D_ARB_PERF_EN defined:
//     - Adds out perf_grants (NUM_REQ*32): per-requester grant count, +1 on each
//       req_ready pulse, wraps at 2^32.
//     - Adds out perf_stall (32): +1 on every cycle where |req_valid and no
//       req_ready pulses, wraps at 2^32.
//     - Both counters clear on rst.
//   L1D_ARB_PERF_EN undefined: those ports and counters are absent; other behaviour
//   is identical.
// TESTING (cache model with L=1 hit, L=20 miss)
// - Single read: req_valid[0], addr 0x100 (hit, data 0xCAFE0001), grant at cycle A.
//   -> req_ready[0] at A; cache_valid only at A+1; resp_valid[0] at A+4;
//   resp_rdata=0xCAFE0001.
// - Conflict: req 0 and 1 both valid from reset and held, 3 accesses each.
//   -> grant order 0,1,0,1,0,1; never two req_ready pulses in one cycle.
// - Write/read: req1 writes 0x0000BEEF to 0x2040, then req0 reads 0x2040.
//   -> write resp_rdata=0; read resp_rdata=0x0000BEEF.
// - Miss: read miss (L=20) granted at A -> resp_valid at A+23; no grant in A+1..A+22.
// - Reset in WAIT: assert rst for 1 cycle during a miss.
//   -> no resp_valid; all outputs 0; next request behaves as the first access from reset.
// - Perf (L1D_ARB_PERF_EN): run the conflict scenario.
//   -> perf_grants = {3,3}; perf_stall = count of cycles with pending req and no grant.

Source files
------------

// File: rtl/l1d_port_arbiter.sv
// Round-robin arbiter sharing one L1 D-cache port among NUM_REQ LSU clients.
// Optional performance counters are enabled with `define L1D_ARB_PERF_EN.
module l1d_port_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ-1:0]    req_we,
  input  logic [NUM_REQ*32-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  cache_valid,
  output logic [31:0]           cache_addr,
  output logic                  cache_we,
  output logic [31:0]           cache_wdata,
  input  logic [31:0]           cache_rdata,
  input  logic [1:0]            cache_status
`ifdef L1D_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0] perf_grants,
  output logic [31:0]           perf_stall
`endif
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] CS_IDLE = 2'd0;
  localparam logic [1:0] CS_DONE = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            grant;
  logic            done;

  logic [31:0]     lat_addr_q;
  logic [31:0]     lat_wdata_q;
  logic            lat_we_q;
  logic [ID_W-1:0] lat_id_q;

  // Round-robin search starting at rr_ptr; the first pending requester wins.
  always_comb begin
    int sum;
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path leaves a value held and no latch is inferred.
    winner = '0;
    found  = 1'b0;
    sum    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(rr_ptr_q) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      if (!found && req_valid[ID_W'(sum)]) begin
        found  = 1'b1;
        winner = ID_W'(sum);
      end
    end
  end

  assign grant     = (state_q == S_IDLE) && found && (cache_status == CS_IDLE);
  assign done      = (state_q == S_WAIT) && (cache_status == CS_DONE);
  assign req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      // Status 1 and the illegal 3 both keep us waiting.
      S_WAIT:  if (cache_status == CS_DONE) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all sequential state is updated with non-blocking '<=' so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_we_q    <= 1'b0;
      lat_id_q    <= '0;
      resp_valid  <= '0;
      resp_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      resp_valid <= '0;
      if (grant) begin
        rr_ptr_q    <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        lat_addr_q  <= req_addr[32*winner +: 32];
        lat_wdata_q <= req_wdata[32*winner +: 32];
        lat_we_q    <= req_we[winner];
        lat_id_q    <= winner;
      end
      if (done) begin
        resp_rdata <= lat_we_q ? 32'h0 : cache_rdata;
        resp_valid <= NUM_REQ'(1) << lat_id_q;
      end
    end
  end

  // Address/data follow the latched copy; only cache_valid marks the request.
  assign cache_valid = (state_q == S_ISSUE);
  assign cache_addr  = lat_addr_q;
  assign cache_we    = lat_we_q;
  assign cache_wdata = lat_wdata_q;

`ifdef L1D_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ready[i]) perf_grants[32*i +: 32] <= perf_grants[32*i +: 32] + 32'd1;
      end
      if (|req_valid && !(|req_ready)) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1d_port_arbiter.sv
// Randomized self-checking bench for l1d_port_arbiter with a transaction-level
// reference model and a hit/miss cache model (L=1 / L=20).
module tb_l1d_port_arbiter;
  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    req_we;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_rdata;
  logic            cache_valid;
  logic [31:0]     cache_addr;
  logic            cache_we;
  logic [31:0]     cache_wdata;
  logic [31:0]     cache_rdata;
  logic [1:0]      cache_status;
`ifdef L1D_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_stall;
`endif

  l1d_port_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .cache_valid(cache_valid), .cache_addr(cache_addr), .cache_we(cache_we),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata), .cache_status(cache_status)
`ifdef L1D_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @t=%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [31:0] a);
    return a[15] ? 20 : 1;
  endfunction

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- cache model ----------------
  logic [31:0] cmem [logic [31:0]];
  int          c_cnt;
  logic [31:0] c_addr;
  bit          spur_en = 0;
  bit          illegal_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      cache_status <= 2'd0;
      cache_rdata  <= 32'h0;
      c_cnt        <= 0;
    end else if (cache_valid) begin
      if (cache_we) cmem[cache_addr] = cache_wdata;
      c_addr       <= cache_addr;
      c_cnt        <= lat_of(cache_addr);
      cache_status <= 2'd1;
    end else if (c_cnt > 1) begin
      c_cnt        <= c_cnt - 1;
      cache_status <= (illegal_en && $urandom_range(0, 3) == 0) ? 2'd3 : 2'd1;
    end else if (c_cnt == 1) begin
      c_cnt        <= 0;
      cache_status <= 2'd2;
      cache_rdata  <= cmem.exists(c_addr) ? cmem[c_addr] : dflt(c_addr);
    end else begin
      cache_status <= (spur_en && $urandom_range(0, 4) == 0) ? 2'd1 : 2'd0;
      cache_rdata  <= $urandom;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  int          t = 0;
  int          m_ptr = 0, m_free = 0, m_resp_t = -1, m_issue_t = -1, m_id = 0;
  logic [31:0] m_addr, m_wdata, m_data;
  logic        m_we;
  int          pg [N];
  int          ps = 0;
  int          grant_t [N];
  int          resp_t [N];
  int          resp_cnt = 0;
  logic [31:0] obs_rdata;
  int          glog [$];

  // Stimulus state per requester.
  int          left [N];
  logic [31:0] a_addr [N];
  logic        a_we [N];
  logic [31:0] a_wdata [N];
  bit          hold = 0;
  bit          rnd_mode = 0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic eval();
    logic [N-1:0] er, erv;
    int w;
    er = '0; erv = '0; w = -1;
    if (t >= m_free && cache_status == 2'd0 && |req_valid)
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (w < 0 && req_valid[j]) w = j;
      end
    if (w >= 0) er[w] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(er));
    if (t == m_resp_t) erv[m_id] = 1'b1;
    check("resp_valid", 64'(resp_valid), 64'(erv));
    if (t == m_resp_t) check("resp_rdata", 64'(resp_rdata), 64'(m_data));
    check("cache_valid", 64'(cache_valid), 64'(t == m_issue_t));
    if (t == m_issue_t) begin
      check("cache_addr", 64'(cache_addr), 64'(m_addr));
      check("cache_we", 64'(cache_we), 64'(m_we));
      if (m_we) check("cache_wdata", 64'(cache_wdata), 64'(m_wdata));
      if (!rst) begin
        m_data = m_we ? 32'h0 : ref_read(m_addr);
        if (m_we) ref_mem[m_addr] = m_wdata;
      end
    end
    for (int i = 0; i < N; i++)
      if (resp_valid[i]) begin
        resp_t[i] = t;
        resp_cnt++;
        obs_rdata = resp_rdata;
      end
    if (w >= 0) begin
      m_ptr     = (w + 1) % N;
      m_id      = w;
      m_addr    = req_addr[32*w +: 32];
      m_we      = req_we[w];
      m_wdata   = req_wdata[32*w +: 32];
      m_issue_t = t + 1;
      m_resp_t  = t + lat_of(m_addr) + 3;
      m_free    = m_resp_t;
      left[w]--;
      grant_t[w] = t;
      glog.push_back(w);
      pg[w]++;
    end else if (|req_valid) begin
      ps++;
    end
    if (rst) begin
      m_ptr = 0; m_free = 0; m_resp_t = -1; m_issue_t = -1; ps = 0;
      for (int i = 0; i < N; i++) pg[i] = 0;
    end
    t++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rnd_mode && left[i] == 0 && $urandom_range(0, 99) < 30) begin
        left[i]    = 1;
        a_addr[i]  = 32'h2000 | (32'($urandom_range(0, 15)) << 2) |
                     (($urandom_range(0, 7) == 0) ? 32'h8000 : 32'h0);
        a_we[i]    = $urandom_range(0, 2) == 0;
        a_wdata[i] = $urandom;
      end
      req_valid[i]         = (left[i] > 0) && !hold;
      req_addr[32*i +: 32]  = a_addr[i];
      req_we[i]            = a_we[i];
      req_wdata[32*i +: 32] = a_wdata[i];
    end
  endtask

  task automatic tick();
    drive();
    @(negedge clk);
    eval();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic we, input logic [31:0] d);
    left[i] = 1; a_addr[i] = a; a_we[i] = we; a_wdata[i] = d;
  endtask

  task automatic wait_grant(input int i, input int bound);
    int k;
    k = 0;
    while (left[i] > 0 && k < bound) begin tick(); k++; end
    check("grant_timeout", 64'(left[i] == 0), 64'd1);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (t <= m_resp_t && k < 100) begin tick(); k++; end
    check("idle_timeout", 64'(t > m_resp_t), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_resp_rdata"}, 64'(resp_rdata), 64'd0);
    check({tag, "_cache_valid"}, 64'(cache_valid), 64'd0);
    check({tag, "_cache_addr"}, 64'(cache_addr), 64'd0);
    check({tag, "_cache_we"}, 64'(cache_we), 64'd0);
    check({tag, "_cache_wdata"}, 64'(cache_wdata), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r0, base;
    for (int i = 0; i < N; i++) begin
      left[i] = 0; a_addr[i] = '0; a_we[i] = 1'b0; a_wdata[i] = '0;
      pg[i] = 0; grant_t[i] = 0; resp_t[i] = 0;
    end
    cmem[32'h100] = 32'hCAFE0001;
    ref_mem[32'h100] = 32'hCAFE0001;
    rst = 1'b1;
    hold = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hold = 0;
    check_all_zero("reset");

    // Conflict: both requesters held from reset, three reads each.
    left[0] = 3; a_addr[0] = 32'h100; a_we[0] = 1'b0;
    left[1] = 3; a_addr[1] = 32'h104; a_we[1] = 1'b0;
    for (int k = 0; k < 60 && (left[0] > 0 || left[1] > 0); k++) tick();
    wait_idle();
    check("conflict_count", 64'(glog.size()), 64'd6);
    foreach (glog[k]) check("conflict_order", 64'(glog[k]), 64'(k % 2));
`ifdef L1D_ARB_PERF_EN
    check("perf_grants0", 64'(perf_grants[31:0]), 64'd3);
    check("perf_grants1", 64'(perf_grants[63:32]), 64'd3);
    check("perf_stall", 64'(perf_stall), 64'(ps));
`endif

    // Single read hit.
    set_req(0, 32'h100, 1'b0, 32'h0);
    wait_grant(0, 10);
    a = grant_t[0];
    wait_idle();
    check("hit_latency", 64'(resp_t[0] - a), 64'd4);
    check("hit_rdata", 64'(obs_rdata), 64'hCAFE0001);

    // Write from req1 then read back from req0.
    set_req(1, 32'h2040, 1'b1, 32'h0000BEEF);
    wait_grant(1, 10);
    wait_idle();
    check("wr_rdata", 64'(obs_rdata), 64'd0);
    set_req(0, 32'h2040, 1'b0, 32'h0);
    wait_grant(0, 10);
    wait_idle();
    check("rd_after_wr", 64'(obs_rdata), 64'h0000BEEF);

    // Miss blocks the port for the full latency.
    set_req(0, 32'h8100, 1'b0, 32'h0);
    wait_grant(0, 10);
    a = grant_t[0];
    set_req(1, 32'h104, 1'b0, 32'h0);
    wait_grant(1, 40);
    check("miss_block", 64'(grant_t[1] - a), 64'd23);
    wait_idle();
    check("miss_latency", 64'(resp_t[0] - a), 64'd23);

    // Reset during a miss drops the response and restarts from rr_ptr=0.
    set_req(0, 32'h8200, 1'b0, 32'h0);
    wait_grant(0, 10);
    repeat (5) tick();
    hold = 1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("post_rst");
    r0 = resp_cnt;
    repeat (25) tick();
    check("rst_drop", 64'(resp_cnt - r0), 64'd0);
    hold = 0;
    set_req(0, 32'h100, 1'b0, 32'h0);
    set_req(1, 32'h104, 1'b0, 32'h0);
    base = glog.size();
    wait_grant(0, 5);
    check("post_rst_first", 64'(glog[base]), 64'd0);
    a = grant_t[0];
    wait_grant(1, 10);
    wait_idle();
    check("post_rst_latency", 64'(resp_t[0] - a), 64'd4);

    // Random traffic with spurious busy and illegal status.
    spur_en = 1; illegal_en = 1; rnd_mode = 1;
    repeat (1500) tick();
    rnd_mode = 0; spur_en = 0;
    for (int k = 0; k < 400 && (left[0] > 0 || left[1] > 0); k++) tick();
    wait_idle();
    check("drain", 64'(left[0] + left[1]), 64'd0);
`ifdef L1D_ARB_PERF_EN
    check("perf_grants0_end", 64'(perf_grants[31:0]), 64'(pg[0]));
    check("perf_grants1_end", 64'(perf_grants[63:32]), 64'(pg[1]));
    check("perf_stall_end", 64'(perf_stall), 64'(ps));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
